// File: rtl/uart_tx_sequencer.sv
// UART transmitter: accepts one word per valid/ready handshake and serialises it as
// start bit, LSB-first data bits, optional parity bit and stop bit.
module uart_tx_sequencer #(
    parameter int CLKS_PER_BIT_P = 16,
    parameter int DATA_BITS_P    = 8,
    parameter int PARITY_P       = 0
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   valid_i,
    input  logic [DATA_BITS_P-1:0] data_i,
    output logic                   ready_o,
    output logic                   tx_o,
    output logic                   busy_o,
    output logic [3:0]             bit_idx_o
);

    localparam int              CNT_W   = $clog2(CLKS_PER_BIT_P);
    localparam logic [CNT_W-1:0] BAUD_TC = CNT_W'(CLKS_PER_BIT_P - 1);
    localparam logic [3:0]      BIT_TC  = 4'(DATA_BITS_P - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]             state_q;
    logic [CNT_W-1:0]       baud_q;
    logic [3:0]             bit_q;
    logic [DATA_BITS_P-1:0] shreg_q;
    logic                   parity_q;
    logic                   tx_q;
    logic                   baud_tc;
    logic                   handshake;

    function automatic logic calc_parity(input logic [DATA_BITS_P-1:0] d);
        return (^d) ^ (PARITY_P == 2);
    endfunction

    assign baud_tc   = (baud_q == BAUD_TC);
    assign handshake = valid_i && (state_q == S_IDLE);

    // Datapath: captured word and its parity carry no reset; state gates their use.
    always_ff @(posedge clk_i) begin
        if (handshake) begin
            shreg_q  <= data_i;
            parity_q <= calc_parity(data_i);
        end else if (state_q == S_DATA && baud_tc) begin
            shreg_q  <= shreg_q >> 1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            if (state_q == S_IDLE || baud_tc) begin
                baud_q <= '0;
            end else begin
                baud_q <= baud_q + CNT_W'(1);
            end

            case (state_q)
                S_IDLE: begin
                    bit_q <= '0;
                    tx_q  <= 1'b1;
                    if (valid_i) begin
                        state_q <= S_START;
                        tx_q    <= 1'b0;
                    end
                end
                S_START: begin
                    if (baud_tc) begin
                        state_q <= S_DATA;
                        tx_q    <= shreg_q[0];
                    end
                end
                S_DATA: begin
                    if (baud_tc) begin
                        if (bit_q == BIT_TC) begin
                            bit_q <= '0;
                            if (PARITY_P != 0) begin
                                state_q <= S_PARITY;
                                tx_q    <= parity_q;
                            end else begin
                                state_q <= S_STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            // shreg_q shifts on this same edge, so the next bit is at index 1
                            bit_q <= bit_q + 4'd1;
                            tx_q  <= shreg_q[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (baud_tc) begin
                        state_q <= S_STOP;
                        tx_q    <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (baud_tc) begin
                        state_q <= S_IDLE;
                        tx_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o   = (state_q == S_IDLE);
    assign busy_o    = ~ready_o;
    assign tx_o      = tx_q;
    assign bit_idx_o = (state_q == S_DATA) ? bit_q : 4'd0;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Scoreboard bench for uart_tx_sequencer: four parameterisations share clock and reset;
// the active one is compared cycle by cycle against an expected line/ready/index queue.
module tb_uart_tx_sequencer;

    typedef struct packed {
        logic       tx;
        logic       rdy;
        logic [3:0] idx;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid [4];
    logic [7:0] data  [4];
    logic       tx    [4];
    logic       ready [4];
    logic       busy  [4];
    logic [3:0] bidx  [4];

    int cpb_t [4] = '{4, 4, 4, 2};
    int db_t  [4] = '{8, 8, 8, 5};
    int par_t [4] = '{0, 1, 2, 0};

    int   cur    = 0;
    int   hs_cnt = 0;
    bit   mon_en = 1'b0;
    int   n_vec  = 0;
    int   n_err  = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    uart_tx_sequencer #(.CLKS_PER_BIT_P(4), .DATA_BITS_P(8), .PARITY_P(0)) dut0 (
        .clk_i(clk), .reset_i(rst), .valid_i(valid[0]), .data_i(data[0]),
        .ready_o(ready[0]), .tx_o(tx[0]), .busy_o(busy[0]), .bit_idx_o(bidx[0]));
    uart_tx_sequencer #(.CLKS_PER_BIT_P(4), .DATA_BITS_P(8), .PARITY_P(1)) dut1 (
        .clk_i(clk), .reset_i(rst), .valid_i(valid[1]), .data_i(data[1]),
        .ready_o(ready[1]), .tx_o(tx[1]), .busy_o(busy[1]), .bit_idx_o(bidx[1]));
    uart_tx_sequencer #(.CLKS_PER_BIT_P(4), .DATA_BITS_P(8), .PARITY_P(2)) dut2 (
        .clk_i(clk), .reset_i(rst), .valid_i(valid[2]), .data_i(data[2]),
        .ready_o(ready[2]), .tx_o(tx[2]), .busy_o(busy[2]), .bit_idx_o(bidx[2]));
    uart_tx_sequencer #(.CLKS_PER_BIT_P(2), .DATA_BITS_P(5), .PARITY_P(0)) dut3 (
        .clk_i(clk), .reset_i(rst), .valid_i(valid[3]), .data_i(data[3][4:0]),
        .ready_o(ready[3]), .tx_o(tx[3]), .busy_o(busy[3]), .bit_idx_o(bidx[3]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (dut%0d, t=%0t): got %0h, expected %0h", tag, cur, $time, got, exp);
        end
    endtask

    // Expected per-cycle line value, ready and bit index for one frame, then the idle cycle.
    function automatic void push_frame(input logic [7:0] d);
        int         c  = cpb_t[cur];
        int         nb = db_t[cur];
        int         p  = par_t[cur];
        logic [7:0] m;
        logic       pb;
        m  = d & 8'((1 << nb) - 1);
        pb = (^m) ^ (p == 2);
        for (int i = 0; i < c; i++) q.push_back(exp_t'{1'b0, 1'b0, 4'd0});
        for (int j = 0; j < nb; j++)
            for (int i = 0; i < c; i++) q.push_back(exp_t'{m[j], 1'b0, 4'(j)});
        if (p != 0)
            for (int i = 0; i < c; i++) q.push_back(exp_t'{pb, 1'b0, 4'd0});
        for (int i = 0; i < c; i++) q.push_back(exp_t'{1'b1, 1'b0, 4'd0});
        q.push_back(exp_t'{1'b1, 1'b1, 4'd0});
    endfunction

    // Model handshake: the model is idle exactly when its queue is empty.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
        end else if (valid[cur] && q.size() == 0) begin
            push_frame(data[cur]);
            hs_cnt++;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            e = (q.size() > 0) ? q.pop_front() : exp_t'{1'b1, 1'b1, 4'd0};
            check("tx",      32'(tx[cur]),    32'(e.tx));
            check("ready",   32'(ready[cur]), 32'(e.rdy));
            check("busy",    32'(busy[cur]),  32'(!e.rdy));
            check("bit_idx", 32'(bidx[cur]),  32'(e.idx));
        end
    end

    task automatic send(input logic [7:0] d, input bit hold);
        int c0;
        c0         = hs_cnt;
        valid[cur] = 1'b1;
        data[cur]  = d;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #2;
            if (hs_cnt != c0) break;
        end
        if (hs_cnt == c0) check("handshake_timeout", 32'd0, 32'd1);
        if (!hold) valid[cur] = 1'b0;
    endtask

    task automatic wait_ready(input int exp_len);
        int n;
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            n++;
            if (ready[cur]) break;
        end
        check("frame_len", 32'(n), 32'(exp_len));
        @(posedge clk); #2;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #2;
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            valid[k] = 1'b0;
            data[k]  = 8'h00;
        end
        rst = 1'b1;
        cycles(3);
        for (int k = 0; k < 4; k++) begin
            cur = k;
            check("rst_tx",      32'(tx[k]),    32'd1);
            check("rst_ready",   32'(ready[k]), 32'd1);
            check("rst_busy",    32'(busy[k]),  32'd0);
            check("rst_bit_idx", 32'(bidx[k]),  32'd0);
        end
        rst = 1'b0;
        cur = 0;
        cycles(1);
        mon_en = 1'b1;

        send(8'h55, 1'b0);
        wait_ready(40);

        cur = 1;
        send(8'h07, 1'b0);
        wait_ready(44);
        cur = 2;
        send(8'h07, 1'b0);
        wait_ready(44);

        cur = 0;
        send(8'hA5, 1'b1);
        send(8'h3C, 1'b0);
        wait_ready(40);

        send(8'hFF, 1'b0);
        data[cur] = 8'h00;
        wait_ready(40);

        // Abort during data bit 3, then a reset that collides with a handshake.
        send(8'h12, 1'b0);
        cycles(17);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        cycles(2);
        valid[cur] = 1'b1;
        data[cur]  = 8'h99;
        rst        = 1'b1;
        cycles(1);
        rst        = 1'b0;
        valid[cur] = 1'b0;
        cycles(2);
        send(8'h81, 1'b0);
        wait_ready(40);

        cur = 3;
        send(8'h1F, 1'b0);
        wait_ready(14);
        send(8'h0A, 1'b0);
        wait_ready(14);

        for (int k = 1; k < 3; k++) begin
            cur = k;
            for (int r = 0; r < 4; r++) begin
                send(8'($urandom_range(0, 255)), 1'b0);
                wait_ready(44);
            end
        end

        cycles(3);
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_sequencer.md
UART_TX_SEQUENCER -- requirements
Module: uart_tx_sequencer

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT_P, default 16, giving clock cycles per UART bit period; legal range 2..65535.
REQ-002 The block SHALL have parameter DATA_BITS_P, default 8, giving data bits per frame; legal range 5..8.
REQ-003 The block SHALL have parameter PARITY_P, default 0: 0 = none, 1 = even, 2 = odd.
REQ-004 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset_i  input  1  synchronous, active-high reset.
REQ-006 valid_i  input  1  upstream has a byte to send.
REQ-007 data_i  input  DATA_BITS_P  byte to send; sampled only on handshake.
REQ-008 ready_o  output  1  block can accept a byte this cycle.
REQ-009 tx_o  output  1  serial line, idle high, registered output.
REQ-010 busy_o  output  1  a frame is in progress, i.e. the inverse of ready_o.
REQ-011 bit_idx_o  output  4  index of the data bit currently driven; 0 outside DATA state.

Function
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-013 The handshake SHALL occur on a rising edge where valid_i and ready_o are both 1; ready_o SHALL be 1 only in IDLE.
REQ-014 On handshake, data_i SHALL be captured into a shift register and the state SHALL go IDLE->START; later changes to data_i SHALL not affect the frame.
REQ-015 A baud counter SHALL count 0..CLKS_PER_BIT_P-1, clear on entry to each bit, and wrap to 0 at terminal count; each bit state advances on the terminal-count cycle.
REQ-016 tx_o SHALL be 0 in START, shift-register LSB in DATA (LSB first), parity bit in PARITY, and 1 in STOP and IDLE.
REQ-017 Each bit SHALL be held on tx_o for exactly CLKS_PER_BIT_P cycles; tx_o SHALL change on the edge after the handshake.
REQ-018 A bit counter SHALL increment at each DATA bit boundary; DATA->PARITY (or ->STOP if PARITY_P=0) after bit DATA_BITS_P-1.
REQ-019 The parity bit SHALL be the XOR of the captured data bits for even parity, and its inverse for odd parity.
REQ-020 STOP SHALL last one bit period, then go to IDLE; ready_o SHALL be 1 on the first cycle after the STOP period.
REQ-021 The frame SHALL occupy exactly (DATA_BITS_P+2+(PARITY_P!=0))*CLKS_PER_BIT_P cycles between handshake edge and ready_o reassertion.
REQ-022 valid_i while busy SHALL be ignored without side effects; back-to-back frames SHALL have no idle gap beyond the IDLE cycle where handshake occurs.
REQ-023 Counter widths SHALL be $clog2(CLKS_PER_BIT_P) and 4 bits; no counter SHALL exceed its terminal value.

Reset
REQ-024 While reset_i is 1, at the next edge: state=IDLE, tx_o=1, ready_o=1, busy_o=0, bit_idx_o=0, counters=0.
REQ-025 reset_i asserted mid-frame SHALL abort the frame; tx_o=1 the following cycle; no partial frame resumes.
REQ-026 reset_i SHALL take priority over a simultaneous handshake; that byte is dropped.

Verification (CLKS_PER_BIT_P=4, DATA_BITS_P=8 unless noted)
REQ-027 PARITY_P=0, send 0x55 -> tx_o: 4 cycles 0, then 1,0,1,0,1,0,1,0 each 4 cycles, 4 cycles 1; ready_o high 40 cycles after handshake.
REQ-028 PARITY_P=1, send 0x07 -> parity bit 1 (three ones); PARITY_P=2, same byte -> parity bit 0; ready_o returns after 44 cycles.
REQ-029 valid_i held high with 0xA5 then 0x3C -> second handshake on first ready_o cycle; second start bit immediately follows first stop bit.
REQ-030 Change data_i from 0xFF to 0x00 one cycle after handshake -> all eight data bits on tx_o are 1.
REQ-031 Assert reset_i for 1 cycle during data bit 3 -> tx_o=1, ready_o=1 the next cycle; new byte 0x81 then transmits correctly.
REQ-032 CLKS_PER_BIT_P=2, DATA_BITS_P=5, send 0x1F -> frame of 14 cycles; bit_idx_o steps 0..4 at 2-cycle intervals during DATA.
